ball_motion_sched: RTL and testbench
====================================

Name: ball_motion_sched

Overview:
- Controller sitting between the NIOS keycode PIO and the ball position datapath.
- Turns up to four simultaneous HID keycodes into queued direction commands.
- Once per frame, evaluates the ball's edge flags and picks the next signed motion vector (keyed command or bounce).
- Hands the vector to the position register with a one-cycle valid strobe, so the position update always uses the freshly decided motion.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of 2)
- STEP, 10'd1, magnitude of motion per frame on either axis
- X_MIN, 10'd0, left playfield bound
- X_MAX, 10'd639, right playfield bound
- Y_MIN, 10'd0, top playfield bound
- Y_MAX, 10'd479, bottom playfield bound

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  synchronous, active-high reset
- keycode  in  32  four HID keycode bytes, slot0 = [7:0] … slot3 = [31:24]
- frame_tick  in  1  one-Clk-wide pulse per video frame
- BallX  in  10  current ball X centre
- BallY  in  10  current ball Y centre
- BallS  in  10  ball radius
- MotionX  out  10  two's-complement X step to apply
- MotionY  out  10  two's-complement Y step to apply
- motion_valid  out  1  one-cycle strobe: Motion outputs are new and must be added this frame
- dir  out  3  last accepted direction, of type dir_t
- overflow  out  1  sticky: a command was dropped because the FIFO was full

Behaviour:
- Decode, per slot:
  - 0x1A → UP, 0x04 → LEFT, 0x16 → DOWN, 0x07 → RIGHT; any other byte → none.
  - held[3:0] = OR across all slots.
- Edge detect:
  - new = held & ~held_q; held_q registers held every cycle.
  - Only the highest-priority new press is pushed, priority UP > DOWN > LEFT > RIGHT; other simultaneous new presses are discarded.
  - A key held continuously produces exactly one push.
- FIFO:
  - Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the push is dropped and overflow is set. overflow clears only on Reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Edge flags use 11-bit unsigned arithmetic, no underflow:
  - bot = BallY+BallS >= Y_MAX
  - top = BallY <= Y_MIN+BallS
  - right = BallX+BallS >= X_MAX
  - left = BallX <= X_MIN+BallS
- FSM state_t:
  - IDLE: on frame_tick → EVAL. A frame_tick arriving in EVAL or COMMIT is ignored.
  - EVAL (1 cycle):
    - If the FIFO is non-empty, pop the head.
    - If the popped direction's own edge flag is set, the command is discarded; otherwise the next motion is that direction's axis = ±STEP and the other axis = 0, and dir is updated.
    - If no command applied, apply the bounce rule, bot > top > right > left: bot → Y=-STEP, top → Y=+STEP, right → X=-STEP, left → X=+STEP; the other axis is held.
    - If no flag is set, motion is held.
  - COMMIT (1 cycle): register MotionX/Y, pulse motion_valid = 1 → IDLE.
- Latency: frame_tick sampled at edge T gives Motion outputs and motion_valid at edge T+2; motion_valid is high for exactly one cycle.
- Negative step: ~STEP+1, 10 bits.
- Reset: MotionX = MotionY = 0, motion_valid = 0, dir = NONE, overflow = 0, FIFO empty, held_q = 0, state IDLE.
- Reset asserted mid-EVAL/COMMIT: the pending decision is discarded and no motion_valid is issued.

Decomposition:
- Package ball_pkg holds:
  - dir_t enum {NONE, UP, DOWN, LEFT, RIGHT}
  - KEY_W/A/S/D keycode constants
  - state_t {IDLE, EVAL, COMMIT}
  - direction priority function
- Sub-module cmd_fifo: parameterised synchronous FIFO of dir_t with push, pop, full, empty, count.

Test Plan:
- Reset, then keycode=0x0000001A held for 3 ticks → first tick gives MotionX=0, MotionY=0x3FF, dir=UP, valid 2 cycles after the tick; the next two ticks push nothing more.
- keycode=0x07041A16 appearing in one cycle, then a tick → UP applied (only one push); FIFO empty after the pop.
- Five distinct presses (D, release, D, …) with no tick → fifth press dropped, overflow=1; four ticks pop four commands.
- BallY=476, BallS=4, no commands, tick → MotionY=0x3FF. Then BallY=3 → MotionY=+1.
- BallX=636, BallS=4, queued RIGHT, tick → command discarded, bounce gives MotionX=0x3FF, dir unchanged.
- Reset asserted the cycle after a tick → no motion_valid, outputs 0, FIFO empty.

Source files
------------

// File: rtl/ball_motion_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ball_pkg
// Purpose  : Shared direction/state types and keycode constants for the
//            ball motion scheduler.
// Revision : 1.0
// ============================================================================
package ball_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        LEFT  = 3'd3,
        RIGHT = 3'd4
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;

    // Bit positions inside the 4-bit held/new-press masks.
    localparam int unsigned HELD_UP    = 0;
    localparam int unsigned HELD_DOWN  = 1;
    localparam int unsigned HELD_LEFT  = 2;
    localparam int unsigned HELD_RIGHT = 3;

    function automatic dir_t dir_priority(input logic [3:0] presses);
        dir_t result;
        result = NONE;
        if (presses[HELD_UP])         result = UP;
        else if (presses[HELD_DOWN])  result = DOWN;
        else if (presses[HELD_LEFT])  result = LEFT;
        else if (presses[HELD_RIGHT]) result = RIGHT;
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ball_motion_sched_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Synchronous FIFO of direction commands; a push into a full FIFO
//            is still accepted when a pop happens in the same cycle.
// Revision : 1.0
// ============================================================================
module cmd_fifo
    import ball_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_push,
    input  dir_t                            i_push_dir,
    input  logic                            i_pop,
    output dir_t                            o_head,
    output logic                            o_full,
    output logic [$clog2(FIFO_DEPTH):0]     o_count
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

    dir_t               r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign o_full    = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dir;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            r_count <= r_count + c_CNT_W'(w_do_push) - c_CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_motion_sched.sv
`default_nettype none
// ============================================================================
// Module   : ball_motion_sched
// Purpose  : Queues keyboard direction commands and, once per frame, picks
//            the next ball motion vector (command or edge bounce).
// Revision : 1.0
// ============================================================================
module ball_motion_sched
    import ball_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [9:0] STEP       = 10'd1,
    parameter logic [9:0] X_MIN      = 10'd0,
    parameter logic [9:0] X_MAX      = 10'd639,
    parameter logic [9:0] Y_MIN      = 10'd0,
    parameter logic [9:0] Y_MAX      = 10'd479
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        frame_tick,
    input  logic [9:0]  BallX,
    input  logic [9:0]  BallY,
    input  logic [9:0]  BallS,
    output logic [9:0]  MotionX,
    output logic [9:0]  MotionY,
    output logic        motion_valid,
    output dir_t        dir,
    output logic        overflow
);

    localparam int         c_CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [9:0] c_STEP_NEG = ~STEP + 10'd1;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         w_slot_hit [4];
    logic [3:0]         w_held;
    logic [3:0]         r_held_q;
    logic [3:0]         w_new;
    logic               w_push;
    dir_t               w_push_dir;
    logic               w_pop;
    dir_t               w_head;
    logic               w_fifo_full;
    logic [c_CNT_W-1:0] w_fifo_count;
    logic               w_have_cmd;
    logic               w_bot, w_top, w_right, w_left;
    logic               w_blocked;
    logic               w_cmd_applied;
    logic [9:0]         w_eval_x, w_eval_y;
    dir_t               w_eval_dir;
    logic [9:0]         r_pend_x, r_pend_y;
    dir_t               r_pend_dir;

    for (genvar s = 0; s < 4; s++) begin : g_slot
        logic [7:0] w_byte;
        assign w_byte        = keycode[8*s +: 8];
        assign w_slot_hit[s] = {w_byte == KEY_D, w_byte == KEY_A,
                                w_byte == KEY_S, w_byte == KEY_W};
    end

    assign w_held     = w_slot_hit[0] | w_slot_hit[1] | w_slot_hit[2] | w_slot_hit[3];
    assign w_new      = w_held & ~r_held_q;
    assign w_push     = |w_new;
    assign w_push_dir = dir_priority(w_new);
    assign w_pop      = (r_state == EVAL);

    cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (Clk),
        .rst        (Reset),
        .i_push     (w_push),
        .i_push_dir (w_push_dir),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_full     (w_fifo_full),
        .o_count    (w_fifo_count)
    );

    assign w_have_cmd = (w_fifo_count != '0);

    // 11-bit compares so BallS added to a coordinate can never wrap.
    assign w_bot   = ({1'b0, BallY} + {1'b0, BallS}) >= {1'b0, Y_MAX};
    assign w_top   = {1'b0, BallY} <= ({1'b0, Y_MIN} + {1'b0, BallS});
    assign w_right = ({1'b0, BallX} + {1'b0, BallS}) >= {1'b0, X_MAX};
    assign w_left  = {1'b0, BallX} <= ({1'b0, X_MIN} + {1'b0, BallS});

    assign w_blocked = ((w_head == UP)    && w_top)  || ((w_head == DOWN)  && w_bot) ||
                       ((w_head == LEFT)  && w_left) || ((w_head == RIGHT) && w_right);

    always_comb begin
        w_eval_x      = MotionX;
        w_eval_y      = MotionY;
        w_eval_dir    = dir;
        w_cmd_applied = 1'b0;
        if (w_have_cmd && !w_blocked) begin
            w_cmd_applied = 1'b1;
            w_eval_dir    = w_head;
            unique case (w_head)
                UP:      begin w_eval_x = '0;         w_eval_y = c_STEP_NEG; end
                DOWN:    begin w_eval_x = '0;         w_eval_y = STEP;       end
                LEFT:    begin w_eval_x = c_STEP_NEG; w_eval_y = '0;         end
                RIGHT:   begin w_eval_x = STEP;       w_eval_y = '0;         end
                default: begin w_cmd_applied = 1'b0;  w_eval_dir = dir;      end
            endcase
        end
        if (!w_cmd_applied) begin
            if (w_bot)        w_eval_y = c_STEP_NEG;
            else if (w_top)   w_eval_y = STEP;
            else if (w_right) w_eval_x = c_STEP_NEG;
            else if (w_left)  w_eval_x = STEP;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (frame_tick) w_state_next = EVAL;
            EVAL:    w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_held_q     <= '0;
            r_pend_x     <= '0;
            r_pend_y     <= '0;
            r_pend_dir   <= NONE;
            MotionX      <= '0;
            MotionY      <= '0;
            motion_valid <= 1'b0;
            dir          <= NONE;
            overflow     <= 1'b0;
        end else begin
            r_held_q     <= w_held;
            motion_valid <= 1'b0;
            if (w_push && w_fifo_full && !w_pop) overflow <= 1'b1;
            if (r_state == EVAL) begin
                r_pend_x   <= w_eval_x;
                r_pend_y   <= w_eval_y;
                r_pend_dir <= w_eval_dir;
            end
            if (r_state == COMMIT) begin
                MotionX      <= r_pend_x;
                MotionY      <= r_pend_y;
                dir          <= r_pend_dir;
                motion_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ball_motion_sched
// Purpose  : Directed bench for ball_motion_sched with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_ball_motion_sched;
    import ball_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] keycode = '0;
    logic        frame_tick = 1'b0;
    logic [9:0]  BallX = 10'd320;
    logic [9:0]  BallY = 10'd240;
    logic [9:0]  BallS = 10'd4;
    logic [9:0]  MotionX, MotionY;
    logic        motion_valid;
    dir_t        dir;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    ball_motion_sched dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .keycode      (keycode),
        .frame_tick   (frame_tick),
        .BallX        (BallX),
        .BallY        (BallY),
        .BallS        (BallS),
        .MotionX      (MotionX),
        .MotionY      (MotionY),
        .motion_valid (motion_valid),
        .dir          (dir),
        .overflow     (overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: command queue, frame phase, expected outputs.
    dir_t       mq[$];
    logic [3:0] m_prev, hv, nw;
    int         phase;
    bit         started = 0;
    logic       m_valid, m_ovf;
    logic [9:0] m_mx, m_my, p_mx, p_my;
    dir_t       m_dir, p_dir, cmd;
    bit         bot, top, rgt, lft, applied;

    function automatic logic [3:0] key_mask(input logic [31:0] kc);
        logic [3:0] m;
        logic [7:0] b;
        m = '0;
        for (int s = 0; s < 4; s++) begin
            b = kc[8*s +: 8];
            if (b == 8'h1A) m[0] = 1'b1;
            if (b == 8'h16) m[1] = 1'b1;
            if (b == 8'h04) m[2] = 1'b1;
            if (b == 8'h07) m[3] = 1'b1;
        end
        return m;
    endfunction

    initial begin
        forever begin
            @(posedge Clk);
            if (Reset) begin
                mq.delete();
                m_prev = '0; phase = 0; m_valid = 0; m_ovf = 0;
                m_mx = '0; m_my = '0; m_dir = NONE; started = 1;
            end else begin
                hv = key_mask(keycode);
                nw = hv & ~m_prev;
                m_prev = hv;
                m_valid = 0;
                if (phase == 2) begin
                    m_mx = p_mx; m_my = p_my; m_dir = p_dir; m_valid = 1; phase = 0;
                end else if (phase == 1) begin
                    bot = (int'(BallY) + int'(BallS)) >= 479;
                    top = int'(BallY) <= int'(BallS);
                    rgt = (int'(BallX) + int'(BallS)) >= 639;
                    lft = int'(BallX) <= int'(BallS);
                    p_mx = m_mx; p_my = m_my; p_dir = m_dir; applied = 0;
                    if (mq.size() > 0) begin
                        cmd = mq.pop_front();
                        if (cmd == UP && !top)    begin p_mx = 0;       p_my = 10'h3FF; applied = 1; end
                        if (cmd == DOWN && !bot)  begin p_mx = 0;       p_my = 10'd1;   applied = 1; end
                        if (cmd == LEFT && !lft)  begin p_mx = 10'h3FF; p_my = 0;       applied = 1; end
                        if (cmd == RIGHT && !rgt) begin p_mx = 10'd1;   p_my = 0;       applied = 1; end
                        if (applied) p_dir = cmd;
                    end
                    if (!applied) begin
                        if (bot)      p_my = 10'h3FF;
                        else if (top) p_my = 10'd1;
                        else if (rgt) p_mx = 10'h3FF;
                        else if (lft) p_mx = 10'd1;
                    end
                    phase = 2;
                end else if (frame_tick) begin
                    phase = 1;
                end
                if (nw != 0) begin
                    if (nw[0])      cmd = UP;
                    else if (nw[1]) cmd = DOWN;
                    else if (nw[2]) cmd = LEFT;
                    else            cmd = RIGHT;
                    if (mq.size() < 4) mq.push_back(cmd);
                    else               m_ovf = 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (started && !Reset) begin
            check("valid", motion_valid, m_valid);
            check("overflow", overflow, m_ovf);
            if (m_valid) begin
                check("motion_x", MotionX, m_mx);
                check("motion_y", MotionY, m_my);
                check("dir", dir, m_dir);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic do_tick();
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) frame_tick = 1'b0;
        cyc(4);
    endtask

    task automatic press(input logic [31:0] kc);
        @(negedge Clk) keycode = kc;
        @(negedge Clk) keycode = '0;
        @(negedge Clk);
    endtask

    initial begin
        cyc(3);
        check("rst_mx", MotionX, 10'd0);
        check("rst_my", MotionY, 10'd0);
        check("rst_valid", motion_valid, 1'b0);
        check("rst_dir", dir, NONE);
        check("rst_ovf", overflow, 1'b0);
        Reset = 1'b0;

        // Held W across three frames: one UP push only.
        keycode = 32'h0000001A;
        do_tick();
        check("s1_mx", MotionX, 10'd0);
        check("s1_my", MotionY, 10'h3FF);
        check("s1_dir", dir, UP);
        do_tick();
        do_tick();
        check("s1_hold_my", MotionY, 10'h3FF);
        keycode = '0;
        cyc(2);

        // Four keys in one cycle: only UP queued.
        @(negedge Clk) keycode = 32'h07041A16;
        @(negedge Clk) keycode = '0;
        do_tick();
        check("s2_my", MotionY, 10'h3FF);
        check("s2_dir", dir, UP);
        BallX = 10'd3;
        do_tick();
        check("s2_empty_mx", MotionX, 10'd1);
        check("s2_empty_my", MotionY, 10'h3FF);
        BallX = 10'd320;

        // Five RIGHT presses without a frame: the fifth overflows.
        repeat (4) press(32'h00000007);
        check("s3_no_ovf", overflow, 1'b0);
        press(32'h00000007);
        check("s3_ovf", overflow, 1'b1);
        repeat (5) do_tick();
        check("s3_mx", MotionX, 10'd1);
        check("s3_my", MotionY, 10'd0);
        check("s3_dir", dir, RIGHT);

        // Bounces off bottom then top.
        BallY = 10'd476;
        do_tick();
        check("s4_bot_my", MotionY, 10'h3FF);
        check("s4_bot_mx", MotionX, 10'd1);
        BallY = 10'd3;
        do_tick();
        check("s4_top_my", MotionY, 10'd1);
        BallY = 10'd240;

        press(32'h00000016);
        do_tick();
        check("s5_down_dir", dir, DOWN);

        // RIGHT into the right wall is discarded, bounce instead.
        BallX = 10'd636;
        press(32'h00000007);
        do_tick();
        check("s5_mx", MotionX, 10'h3FF);
        check("s5_my", MotionY, 10'd1);
        check("s5_dir", dir, DOWN);
        BallX = 10'd320;

        // Reset landing on the EVAL cycle.
        press(32'h0000001A);
        press(32'h00000004);
        @(negedge Clk) frame_tick = 1'b1;
        @(negedge Clk) begin frame_tick = 1'b0; Reset = 1'b1; end
        cyc(2);
        check("s6_valid", motion_valid, 1'b0);
        check("s6_mx", MotionX, 10'd0);
        check("s6_my", MotionY, 10'd0);
        check("s6_dir", dir, NONE);
        check("s6_ovf", overflow, 1'b0);
        Reset = 1'b0;
        cyc(3);
        do_tick();
        check("s6_empty_mx", MotionX, 10'd0);
        check("s6_empty_my", MotionY, 10'd0);
        check("s6_empty_dir", dir, NONE);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
